// File: rtl/key_press_classifier_if.sv
// Button-side bundle for key_press_classifier: raw key input plus debounced level and gesture pulses.
interface key_press_classifier_if;
    logic key_in;
    logic key_level;
    logic press_pulse;
    logic short_pulse;
    logic long_pulse;
    logic double_pulse;
    logic hold;

    modport master (
        output key_in,
        input  key_level, press_pulse, short_pulse, long_pulse, double_pulse, hold
    );

    modport slave (
        input  key_in,
        output key_level, press_pulse, short_pulse, long_pulse, double_pulse, hold
    );
endinterface

// File: rtl/key_press_classifier.sv
// Synchronises and debounces an active-low push-button and classifies short/long/double presses.
// Optional feature macro: KEY_REPEAT_EN (long_pulse auto-repeats every REPEAT_CYC while held).
module key_press_classifier #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int DCLICK_CYC   = 15_000_000,
    parameter int REPEAT_CYC   = 10_000_000
) (
    input logic               clk,
    input logic               rst,
    key_press_classifier_if.slave kp
);

    localparam int TMAX_LD = (LONG_CYC > DCLICK_CYC) ? LONG_CYC : DCLICK_CYC;
    localparam int TMAX    = (TMAX_LD > REPEAT_CYC) ? TMAX_LD : REPEAT_CYC;
    localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int DW      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYC - 1);
    localparam logic [TW-1:0] DCLICK_LAST = TW'(DCLICK_CYC - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [TW-1:0] REP_LAST    = TW'(REPEAT_CYC - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        WAIT2,
        PRESSED2,
        LONG
    } state_t;

    // ---------------- input synchroniser and debounce ----------------
    logic          sync1, sync2, stable;
    logic [DW-1:0] deb_cnt;
    logic          deb_fire, press_evt, release_evt;

    // Press/release events are the cycle key_level is about to change, so the FSM
    // moves on the same edge the debounced level does.
    assign deb_fire    = (sync2 != stable) && (deb_cnt == DEB_LAST);
    assign press_evt   = deb_fire && !sync2;
    assign release_evt = deb_fire &&  sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            stable  <= 1'b1;
            deb_cnt <= '0;
        end else begin
            sync1 <= kp.key_in;
            sync2 <= sync1;
            if (sync2 == stable) begin
                deb_cnt <= '0;
            end else if (deb_fire) begin
                stable  <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    assign kp.key_level = ~stable;

    // ---------------- gesture FSM ----------------
    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic          press_nxt, short_nxt, long_nxt, double_nxt, rep_reload;
    logic          press_q, short_q, long_q, double_q, hold_q;

    always_comb begin
        state_nxt  = state;
        press_nxt  = 1'b0;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        double_nxt = 1'b0;
        rep_reload = 1'b0;
        case (state)
            IDLE: begin
                if (press_evt) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                end
            end
            PRESSED: begin
                if (release_evt) begin
                    state_nxt = WAIT2;
                end else if (timer == LONG_LAST) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                end
            end
            WAIT2: begin
                // a press landing on the timeout cycle still counts as the second click
                if (press_evt) begin
                    state_nxt = PRESSED2;
                    press_nxt = 1'b1;
                end else if (timer == DCLICK_LAST) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end
            end
            PRESSED2: begin
                if (release_evt) begin
                    state_nxt  = IDLE;
                    double_nxt = 1'b1;
                end else if (timer == LONG_LAST) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                end
            end
            LONG: begin
                if (release_evt) begin
                    state_nxt = IDLE;
`ifdef KEY_REPEAT_EN
                end else if (timer == REP_LAST) begin
                    long_nxt   = 1'b1;
                    rep_reload = 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            press_q  <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            press_q  <= press_nxt;
            short_q  <= short_nxt;
            long_q   <= long_nxt;
            double_q <= double_nxt;
            hold_q   <= (state_nxt == LONG);
            // shared timer: restarts on every state change, sticks at all-ones
            if ((state_nxt != state) || rep_reload) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + TW'(1);
            end
        end
    end

    assign kp.press_pulse  = press_q;
    assign kp.short_pulse  = short_q;
    assign kp.long_pulse   = long_q;
    assign kp.double_pulse = double_q;
    assign kp.hold         = hold_q;

endmodule
